// File: rtl/peak_energy_window.sv
// peak_energy_window
// Computes the energy I*I + Q*Q of each complex sample. For every window of
// 2^LOG2_WINDOW accepted samples it emits the peak energy, the average energy
// (floor of sum / N), the position of the peak and a running window tag.
// The result forms a numerator/denominator pair for a downstream divider.
// Pipeline: stage 1 registers energy and position, stage 2 accumulates.
// The final sample of a window is folded in on the same edge that
// registers the outputs.

module peak_energy_window #(
    parameter int IQ_WIDTH    = 16,
    parameter int LOG2_WINDOW = 6,
    parameter int USER_WIDTH  = 8
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic [2*IQ_WIDTH-1:0]     s_axis_in_tdata,
    input  logic                      s_axis_in_tvalid,
    output logic [2*IQ_WIDTH-1:0]     numerator_o,
    output logic [2*IQ_WIDTH-1:0]     denominator_o,
    output logic [LOG2_WINDOW-1:0]    peak_idx_o,
    output logic [USER_WIDTH-1:0]     user_o,
    output logic                      valid_o
);

    localparam int EW    = 2 * IQ_WIDTH;
    localparam int ACC_W = EW + LOG2_WINDOW;

    // Sample halves, sign-extended to the product width before squaring.
    logic signed [IQ_WIDTH-1:0] w_i;
    logic signed [IQ_WIDTH-1:0] w_q;
    logic signed [EW-1:0]       w_i_ext;
    logic signed [EW-1:0]       w_q_ext;
    logic signed [EW-1:0]       w_ii;
    logic signed [EW-1:0]       w_qq;
    logic [EW-1:0]              w_energy;

    assign w_i     = s_axis_in_tdata[IQ_WIDTH-1:0];
    assign w_q     = s_axis_in_tdata[EW-1:IQ_WIDTH];
    assign w_i_ext = EW'(w_i);
    assign w_q_ext = EW'(w_q);
    assign w_ii    = w_i_ext * w_i_ext;
    assign w_qq    = w_q_ext * w_q_ext;
    // Each square is at most 2^(EW-2), so the unsigned sum never wraps.
    assign w_energy = $unsigned(w_ii) + $unsigned(w_qq);

    // Stage 1 registers.
    logic [EW-1:0]          r_energy;
    logic [LOG2_WINDOW-1:0] r_s1_pos;
    logic                   r_s1_valid;
    logic [LOG2_WINDOW-1:0] r_pos;

    // Stage 2 registers.
    logic [ACC_W-1:0]       r_acc;
    logic [EW-1:0]          r_peak;
    logic [LOG2_WINDOW-1:0] r_peak_idx;
    logic [USER_WIDTH-1:0]  r_user;

    // Stage 2 next values, including the sample currently in stage 1.
    logic                   w_first;
    logic                   w_last;
    logic                   w_new_peak;
    logic [ACC_W-1:0]       w_acc_nxt;
    logic [EW-1:0]          w_peak_nxt;
    logic [LOG2_WINDOW-1:0] w_idx_nxt;

    // Stage 1: register energy and window position of each accepted sample.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_energy   <= '0;
            r_s1_pos   <= '0;
            r_s1_valid <= 1'b0;
            r_pos      <= '0;
        end else begin
            r_s1_valid <= s_axis_in_tvalid;
            if (s_axis_in_tvalid) begin
                r_energy <= w_energy;
                r_s1_pos <= r_pos;
                r_pos    <= r_pos + LOG2_WINDOW'(1);
            end
        end
    end

    // Position 0 restarts the window. Strict compare keeps the earliest index on ties.
    always_comb begin
        w_first    = (r_s1_pos == '0);
        w_last     = (r_s1_pos == '1);
        w_new_peak = w_first || (r_energy > r_peak);
        w_acc_nxt  = w_first ? ACC_W'(r_energy) : (r_acc + ACC_W'(r_energy));
        w_peak_nxt = w_new_peak ? r_energy : r_peak;
        w_idx_nxt  = w_new_peak ? r_s1_pos : r_peak_idx;
    end

    // Stage 2: accumulate and track peak; emit outputs at the last position.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_acc         <= '0;
            r_peak        <= '0;
            r_peak_idx    <= '0;
            r_user        <= '0;
            numerator_o   <= '0;
            denominator_o <= '0;
            peak_idx_o    <= '0;
            user_o        <= '0;
            valid_o       <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            if (r_s1_valid) begin
                r_acc      <= w_acc_nxt;
                r_peak     <= w_peak_nxt;
                r_peak_idx <= w_idx_nxt;
                if (w_last) begin
                    numerator_o   <= w_peak_nxt;
                    denominator_o <= w_acc_nxt[ACC_W-1:LOG2_WINDOW];
                    peak_idx_o    <= w_idx_nxt;
                    user_o        <= r_user;
                    valid_o       <= 1'b1;
                    r_user        <= r_user + USER_WIDTH'(1);
                end
            end
        end
    end

endmodule
